// File: rtl/noc_pkg.sv
// noc_pkg: shared types and arbitration helpers for the butterfly-fat-tree NoC
package noc_pkg;
    localparam int NOC_N = 8;
    localparam int NOC_A_W = $clog2(NOC_N) + 1;
    localparam int NOC_D_W = 32;
    localparam int MAX_K = 32;

    typedef enum logic {IDLE, LOCKED} state_t;

    typedef struct packed {
        logic [NOC_A_W-1:0] addr;
        logic [NOC_D_W-1:0] data;
    } flit_t;

    // First set bit of req[n-1:0] scanning circularly upward from ptr; 0 if none.
    function automatic logic [4:0] rr_pick(input logic [MAX_K-1:0] req, input logic [4:0] ptr, input int n);
        logic [4:0] r;
        logic [4:0] j;
        r = '0;
        for (int i = MAX_K - 1; i >= 0; i--) begin
            j = 5'((int'(ptr) + i) % n);
            if (i < n && req[j]) r = j;
        end
        return r;
    endfunction
endpackage

// File: rtl/noc_inj_arb_if.sv
// noc_inj_arb_if: requester-side and NoC-side flit handshake bundle
interface noc_inj_arb_if import noc_pkg::*; #(
    parameter int K = 4,
    parameter int A_W = NOC_A_W,
    parameter int D_W = NOC_D_W
);
    logic [K-1:0] req_v;
    logic [K-1:0] req_last;
    logic [K*A_W-1:0] req_addr;
    logic [K*D_W-1:0] req_data;
    logic [K-1:0] req_bp;
    logic o_v;
    logic [A_W-1:0] o_addr;
    logic [D_W-1:0] o_data;
    logic o_bp;

    modport master(output req_v, req_last, req_addr, req_data, o_bp, input req_bp, o_v, o_addr, o_data);
    modport slave(input req_v, req_last, req_addr, req_data, o_bp, output req_bp, o_v, o_addr, o_data);
endinterface

// File: rtl/noc_skid2.sv
// noc_skid2: 2-entry skid FIFO; in_rdy depends only on registers, never on out_bp
module noc_skid2 #(
    parameter int W = 36
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic in_v,
    output logic in_rdy,
    input  logic [W-1:0] in_flit,
    output logic out_v,
    input  logic out_bp,
    output logic [W-1:0] out_flit,
    output logic [1:0] count
);
    logic [W-1:0] e0, e1;
    logic push, pop;

    always_comb begin
        in_rdy = ce & (count != 2'd2);
        out_v = ce & (count != 2'd0);
        push = in_v & in_rdy;
        pop = out_v & ~out_bp;
        out_flit = e0;
    end

    always_ff @(posedge clk)
        if (rst) count <= '0;
        else count <= count + {1'b0, push} - {1'b0, pop};

    // Push+pop together only happens at count 1, so the new flit goes straight to the head.
    always_ff @(posedge clk) begin
        if (pop) e0 <= push ? in_flit : e1;
        else if (push && count == 2'd0) e0 <= in_flit;
        if (push && !pop) e1 <= in_flit;
    end
endmodule

// File: rtl/noc_inj_arb.sv
// noc_inj_arb: packet-granular round-robin injection arbiter for K local requesters
// sharing one leaf injection port, output registered through a 2-entry skid buffer.
module noc_inj_arb import noc_pkg::*; #(
    parameter int N = NOC_N,
    parameter int A_W = $clog2(N) + 1,
    parameter int D_W = 32,
    parameter int K = 4,
    parameter int P_W = (K > 1) ? $clog2(K) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    noc_inj_arb_if.slave bus,
    output logic busy
);
    typedef struct packed {
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } flit_l;

    state_t state;
    logic [P_W-1:0] rr_ptr, owner, pick, g;
    logic skid_rdy, acc;
    logic [1:0] count;
    logic [K-1:0] gnt;
    flit_l in_flit, out_flit;

    // In IDLE the pick lands on an invalid requester only when nobody is valid.
    always_comb begin
        pick = P_W'(rr_pick(MAX_K'(bus.req_v), 5'(rr_ptr), K));
        g = (state == LOCKED) ? owner : pick;
        acc = bus.req_v[g] & skid_rdy & ~rst;
        gnt = acc ? (K'(1) << g) : '0;
        in_flit = '{addr: bus.req_addr[g*A_W +: A_W], data: bus.req_data[g*D_W +: D_W]};
        bus.req_bp = bus.req_v & ~gnt;
        bus.o_addr = out_flit.addr;
        bus.o_data = out_flit.data;
        busy = (state == LOCKED) | (count != 2'd0);
    end

    // In LOCKED g is the owner, so one update rule covers both states.
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
        end else if (acc) begin
            if (bus.req_last[g]) begin
                state <= IDLE;
                rr_ptr <= (g == P_W'(K - 1)) ? '0 : g + P_W'(1);
            end else begin
                state <= LOCKED;
                owner <= g;
            end
        end

    noc_skid2 #(.W(A_W + D_W)) skid (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .in_v(acc),
        .in_rdy(skid_rdy),
        .in_flit(in_flit),
        .out_v(bus.o_v),
        .out_bp(bus.o_bp),
        .out_flit(out_flit),
        .count(count)
    );
endmodule

// File: tb/tb_noc_inj_arb.sv
// tb_noc_inj_arb: directed scenario bench for noc_inj_arb (K=4, A_W=4, D_W=32)
module tb_noc_inj_arb;
    import noc_pkg::*;
    localparam int K = 4;
    localparam int A_W = 4;
    localparam int D_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b1;
    logic busy;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    noc_inj_arb_if #(.K(K), .A_W(A_W), .D_W(D_W)) bus();

    noc_inj_arb #(.N(8), .A_W(A_W), .D_W(D_W), .K(K)) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .bus(bus.slave),
        .busy(busy)
    );

    task automatic set_req(input int k, input logic v, input logic last, input logic [31:0] d);
        bus.req_v[k] = v;
        bus.req_last[k] = last;
        bus.req_addr[k*A_W +: A_W] = A_W'(k);
        bus.req_data[k*D_W +: D_W] = d;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        ce = 1'b1;
        bus.req_v = '0;
        bus.o_bp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        bus.req_v = 4'hF;
        bus.req_last = 4'hF;
        #1;
        n_tests++;
        if (bus.req_bp !== 4'hF) begin n_fail++; $display("FAIL rst_bp: got %b want 1111", bus.req_bp); end
        n_tests++;
        if (bus.o_v !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_ov_busy: got o_v=%b busy=%b want 0 0", bus.o_v, busy); end
        @(negedge clk);
        n_tests++;
        if (dut.state !== IDLE || dut.rr_ptr !== 2'd0 || dut.count !== 2'd0) begin
            n_fail++; $display("FAIL rst_regs: got state=%0d ptr=%0d count=%0d want 0 0 0", dut.state, dut.rr_ptr, dut.count);
        end
        rst = 1'b0;
        bus.req_v = '0;
    endtask

    task automatic test_fairness;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        logic [3:0] one = 4'b0001;
        logic [3:0] eb;
        for (int k = 0; k < K; k++) set_req(k, 1'b1, 1'b1, 32'h10 + k);
        for (int i = 0; i < 5; i++) begin
            #1;
            eb = ~(one << exp_g[i]);
            n_tests++;
            if (bus.req_bp !== eb) begin n_fail++; $display("FAIL fair_bp c%0d: got %b want %b", i, bus.req_bp, eb); end
            n_tests++;
            if (bus.o_v !== (i > 0)) begin n_fail++; $display("FAIL fair_ov c%0d: got %b want %b", i, bus.o_v, i > 0); end
            if (i > 0) begin
                n_tests++;
                if (bus.o_data !== 32'h10 + exp_g[i-1] || bus.o_addr !== A_W'(exp_g[i-1])) begin
                    n_fail++; $display("FAIL fair_out c%0d: got %h/%h want %h/%h", i, bus.o_addr, bus.o_data, exp_g[i-1], 32'h10 + exp_g[i-1]);
                end
            end
            @(negedge clk);
        end
        bus.req_v = '0;
        #1;
        n_tests++;
        if (bus.o_v !== 1'b1 || bus.o_data !== 32'h10) begin n_fail++; $display("FAIL fair_tail: got %b/%h want 1/00000010", bus.o_v, bus.o_data); end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.o_v !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fair_drain: got o_v=%b busy=%b want 0 0", bus.o_v, busy); end
    endtask

    task automatic test_packet_lock;
        logic [3:0] eb [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic ov [6] = '{0, 1, 1, 1, 1, 0};
        logic [31:0] od [6] = '{0, 32'hB0, 32'hB1, 32'hB2, 32'hC0, 0};
        logic eby [6] = '{0, 1, 1, 1, 1, 0};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin set_req(0, 1, 0, 32'hB0); set_req(2, 1, 1, 32'hC0); end
                1: set_req(0, 1, 0, 32'hB1);
                2: set_req(0, 1, 1, 32'hB2);
                3: bus.req_v[0] = 1'b0;
                4: bus.req_v[2] = 1'b0;
                default: ;
            endcase
            #1;
            n_tests++;
            if (bus.req_bp !== eb[c]) begin n_fail++; $display("FAIL lock_bp c%0d: got %b want %b", c, bus.req_bp, eb[c]); end
            n_tests++;
            if (bus.o_v !== ov[c] || (ov[c] && bus.o_data !== od[c])) begin
                n_fail++; $display("FAIL lock_out c%0d: got %b/%h want %b/%h", c, bus.o_v, bus.o_data, ov[c], od[c]);
            end
            n_tests++;
            if (busy !== eby[c]) begin n_fail++; $display("FAIL lock_busy c%0d: got %b want %b", c, busy, eby[c]); end
            @(negedge clk);
        end
    endtask

    task automatic test_bp_fill;
        logic [3:0] eb [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic ov [7] = '{0, 1, 1, 1, 1, 1, 0};
        logic [31:0] od [7] = '{0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 0};
        do_reset();
        bus.o_bp = 1'b1;
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: set_req(1, 1, 1, 32'hA0);
                1: set_req(1, 1, 1, 32'hA1);
                2: set_req(1, 1, 1, 32'hA2);
                3: bus.o_bp = 1'b0;
                5: bus.req_v = '0;
                default: ;
            endcase
            #1;
            n_tests++;
            if (bus.req_bp !== eb[c]) begin n_fail++; $display("FAIL bpf_bp c%0d: got %b want %b", c, bus.req_bp, eb[c]); end
            n_tests++;
            if (bus.o_v !== ov[c] || (ov[c] && bus.o_data !== od[c])) begin
                n_fail++; $display("FAIL bpf_out c%0d: got %b/%h want %b/%h", c, bus.o_v, bus.o_data, ov[c], od[c]);
            end
            if (c == 2) begin
                n_tests++;
                if (dut.count !== 2'd2) begin n_fail++; $display("FAIL bpf_count: got %0d want 2", dut.count); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_skip;
        do_reset();
        set_req(2, 1, 1, 32'h22);
        #1;
        n_tests++;
        if (bus.req_bp !== 4'b0000) begin n_fail++; $display("FAIL wrap_pre_bp: got %b want 0000", bus.req_bp); end
        @(negedge clk);
        set_req(0, 1, 1, 32'h30);
        set_req(2, 1, 1, 32'h32);
        #1;
        n_tests++;
        if (dut.rr_ptr !== 2'd3 || bus.req_bp !== 4'b0100) begin
            n_fail++; $display("FAIL wrap_g0: got ptr=%0d bp=%b want 3 0100", dut.rr_ptr, bus.req_bp);
        end
        n_tests++;
        if (bus.o_data !== 32'h22) begin n_fail++; $display("FAIL wrap_o0: got %h want 00000022", bus.o_data); end
        @(negedge clk);
        #1;
        n_tests++;
        if (dut.rr_ptr !== 2'd1 || bus.req_bp !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_g2: got ptr=%0d bp=%b want 1 0001", dut.rr_ptr, bus.req_bp);
        end
        n_tests++;
        if (bus.o_data !== 32'h30) begin n_fail++; $display("FAIL wrap_o1: got %h want 00000030", bus.o_data); end
        @(negedge clk);
        bus.req_v = '0;
        #1;
        n_tests++;
        if (dut.rr_ptr !== 2'd3 || bus.o_data !== 32'h32) begin
            n_fail++; $display("FAIL wrap_end: got ptr=%0d data=%h want 3 00000032", dut.rr_ptr, bus.o_data);
        end
        @(negedge clk);
    endtask

    task automatic test_ce_gating;
        do_reset();
        set_req(1, 1, 1, 32'hD0);
        @(negedge clk);
        set_req(1, 1, 1, 32'hD1);
        #1;
        n_tests++;
        if (bus.req_bp !== 4'b0000 || bus.o_data !== 32'hD0) begin
            n_fail++; $display("FAIL ce_pre: got bp=%b data=%h want 0000 000000d0", bus.req_bp, bus.o_data);
        end
        @(negedge clk);
        set_req(1, 1, 1, 32'hD2);
        ce = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (bus.o_v !== 1'b0 || bus.req_bp !== 4'b0010) begin
                n_fail++; $display("FAIL ce_off c%0d: got o_v=%b bp=%b want 0 0010", c, bus.o_v, bus.req_bp);
            end
            n_tests++;
            if (dut.state !== IDLE || dut.count !== 2'd1 || dut.rr_ptr !== 2'd2) begin
                n_fail++; $display("FAIL ce_hold c%0d: got state=%0d count=%0d ptr=%0d want 0 1 2", c, dut.state, dut.count, dut.rr_ptr);
            end
            @(negedge clk);
        end
        ce = 1'b1;
        #1;
        n_tests++;
        if (bus.req_bp !== 4'b0000 || bus.o_v !== 1'b1 || bus.o_data !== 32'hD1) begin
            n_fail++; $display("FAIL ce_resume: got bp=%b o=%b/%h want 0000 1/000000d1", bus.req_bp, bus.o_v, bus.o_data);
        end
        @(negedge clk);
        bus.req_v = '0;
        #1;
        n_tests++;
        if (bus.o_v !== 1'b1 || bus.o_data !== 32'hD2) begin n_fail++; $display("FAIL ce_tail: got %b/%h want 1/000000d2", bus.o_v, bus.o_data); end
        @(negedge clk);
    endtask

    task automatic test_mid_reset;
        do_reset();
        set_req(1, 1, 0, 32'hE0);
        #1;
        n_tests++;
        if (bus.req_bp !== 4'b0000) begin n_fail++; $display("FAIL mrst_acc: got %b want 0000", bus.req_bp); end
        @(negedge clk);
        rst = 1'b1;
        set_req(1, 1, 1, 32'hE1);
        set_req(3, 1, 1, 32'hF0);
        #1;
        n_tests++;
        if (bus.req_bp !== 4'b1010 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mrst_during: got bp=%b busy=%b want 1010 1", bus.req_bp, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req_v[1] = 1'b0;
        #1;
        n_tests++;
        if (bus.o_v !== 1'b0 || busy !== 1'b0 || dut.state !== IDLE || dut.rr_ptr !== 2'd0) begin
            n_fail++; $display("FAIL mrst_after: got o_v=%b busy=%b state=%0d ptr=%0d want 0 0 0 0", bus.o_v, busy, dut.state, dut.rr_ptr);
        end
        n_tests++;
        if (bus.req_bp !== 4'b0000) begin n_fail++; $display("FAIL mrst_grant: got %b want 0000", bus.req_bp); end
        @(negedge clk);
        bus.req_v = '0;
        #1;
        n_tests++;
        if (bus.o_v !== 1'b1 || bus.o_data !== 32'hF0 || bus.o_addr !== 4'd3) begin
            n_fail++; $display("FAIL mrst_out: got %b/%h/%h want 1/3/000000f0", bus.o_v, bus.o_addr, bus.o_data);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.req_v = '0;
        bus.req_last = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.o_bp = 1'b0;
        @(negedge clk);
        test_reset();
        test_fairness();
        test_packet_lock();
        test_bp_fill();
        test_wrap_skip();
        test_ce_gating();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/noc_inj_arb.md
Name: noc_inj_arb

Overview:
- Client-side injection arbiter for the backpressured butterfly-fat-tree NoC.
- Shares one leaf injection port, which feeds the l or r input of a level-0 route node, among K local requesters.
- Round-robin arbitration at packet granularity: a multi-flit packet is never interleaved with another requester's flits.
- Output is registered through a 2-entry skid buffer, so downstream bp never combinationally reaches requester bp.

Parameters:
- N, 8: number of NoC clients.
- A_W, $clog2(N)+1: flit address width.
- D_W, 32: flit data width.
- K, 4: number of local requesters (K>=1).
- P_W, (K>1)?$clog2(K):1: round-robin pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ce  in  1  clock enable
- req_v  in  K  per-requester flit valid
- req_last  in  K  flit is last of its packet
- req_addr  in  K*A_W  packed destination addresses, requester k at [k*A_W +: A_W]
- req_data  in  K*D_W  packed data, requester k at [k*D_W +: D_W]
- req_bp  out  K  requester k flit not accepted this cycle
- o_v  out  1  output flit valid
- o_addr  out  A_W  output flit address
- o_data  out  D_W  output flit data
- o_bp  in  1  output backpressured (NoC did not consume)
- busy  out  1  packet in progress or skid buffer non-empty

Behaviour:
- Reset is synchronous, active-high (rst), on clk.
- Reset values: state=IDLE, rr_ptr=0, owner=0, skid count=0, o_v=0, busy=0.
- While rst=1, nothing is accepted: req_bp = req_v.
- Handshake:
  - A flit is transferred when valid=1 and bp=0 in the same cycle.
  - A source holding bp=1 must keep valid, addr, data and last stable.
  - A flit with valid=0 never asserts bp.
- Skid ready: in_rdy = ce & (count<2). It is computed from registers only and never from o_bp.
- IDLE state:
  - If in_rdy, grant g = first k with req_v[k]=1, scanning circularly from rr_ptr.
  - The flit from g is accepted the same cycle.
  - If req_last[g]=0: go to LOCKED, owner<=g.
  - If req_last[g]=1: stay in IDLE, rr_ptr<=(g+1) mod K.
- LOCKED state:
  - Only owner is eligible; every other valid requester sees bp=1.
  - Owner is accepted when in_rdy.
  - On an accepted flit with last=1: go to IDLE, rr_ptr<=(owner+1) mod K.
  - Owner dropping req_v mid-packet is legal. The lock holds, with no timeout.
- req_bp[k] = req_v[k] & ~(granted_k & in_rdy).
- Skid buffer:
  - 2-entry FIFO.
  - o_v = ce & (count>0); o_addr and o_data show the head entry.
  - Pop when o_v & ~o_bp. Push when a flit is accepted.
  - Push and pop in the same cycle leave count unchanged.
  - At count=2 there is no push, since in_rdy=0.
  - Order is preserved.
- Latency: a flit accepted in cycle t appears on o_* at t+1 at the earliest.
- Throughput: 1 flit/cycle sustained when o_bp=0.
- Wrap-around: rr_ptr goes from K-1 to 0. With K=1 the pointer stays 0 and only the lock behaviour applies.
- ce=0:
  - All registers hold.
  - Nothing is accepted (req_bp = req_v).
  - o_v=0, so no pop occurs.
- busy = (state==LOCKED) | (count!=0).
- Reset asserted mid-packet: the buffered flits and the lock are discarded. The requester must restart the packet after reset.

Decomposition:
- Shared package noc_pkg holds:
  - state enum {IDLE, LOCKED};
  - a flit struct type parameterised by A_W/D_W (addr, data);
  - the circular priority-pick function rr_pick(req, ptr), used here and reusable by route-node arbiters.
- Sub-module noc_skid2:
  - 2-entry skid buffer with ports in_v/in_rdy/in_flit/out_v/out_bp/out_flit/count;
  - instantiated once.

Test Plan:
- Single-flit fairness: K=4, all req_v=1, req_last=1, o_bp=0, rr_ptr=0 after reset. Grants must follow 0,1,2,3,0 on consecutive cycles. o_v=1 from cycle 2, one flit per cycle, in that order.
- Packet lock: req0 sends a 3-flit packet (last on flit 3) while req2 is valid throughout. req2 bp=1 for the 3 accept cycles and is granted on the 4th. Output shows req0 flits 1,2,3 then req2 flit 1, with no interleave.
- Backpressure fill: hold o_bp=1 with req1 streaming. Exactly 2 flits are accepted, then req_bp[1]=1 and count=2. Release o_bp: head pops the same cycle and in_rdy=1 the next cycle. No flit is lost or duplicated (data 0xA0, 0xA1, 0xA2 in order).
- Wrap and skip: rr_ptr=3, req_v=4'b0101. Grant goes to 0, then rr_ptr=1, then grant goes to 2.
- ce gating: ce=0 for 3 cycles mid-stream. o_v=0 and req_bp=req_v during those cycles. State, count and rr_ptr are unchanged, and the stream resumes identically.
- Mid-packet reset: rst asserted after flit 1 of a 2-flit packet. Next cycle o_v=0, busy=0, state=IDLE, rr_ptr=0, and a new packet from req3 is granted immediately.
